// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = loader side, slave = byte source plus memory write port.
interface inst_loader_if #(
    parameter int AW = 32,
    parameter int IW = 32
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [IW-1:0] wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, we, waddr, wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction memory writer: takes a little-endian length header and
// word payload from a byte stream and issues one write strobe per assembled word.
module inst_loader #(
    parameter int AW    = 32,
    parameter int IW    = 32,
    parameter int DEPTH = 16
) (
    input  logic          wclk,
    input  logic          rst_n,
    input  logic          start,
    inst_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int BPW = IW / 8;
    // One counter serves both the 4-byte header and the BPW-byte word.
    localparam int BIW = (BPW > 4) ? $clog2(BPW) : 2;
    localparam logic [32:0] CAP = 33'(1) << (DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      count_reg, count_next;
    logic [31:0]      word_idx_reg, word_idx_next;
    logic [BIW-1:0]   byte_idx_reg, byte_idx_next;
    logic [31:0]      n_full;

    // Header bytes shift in from the top, so the first byte ends up in [7:0].
    assign n_full = {bus.byte_data, count_reg[31:8]};

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            word_idx_reg <= '0;
            byte_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            word_idx_reg <= word_idx_next;
            byte_idx_reg <= byte_idx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        word_idx_next  = word_idx_reg;
        byte_idx_next  = byte_idx_reg;
        bus.byte_ready = 1'b0;
        bus.we         = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        err            = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_LEN;
                    count_next    = '0;
                    word_idx_next = '0;
                    byte_idx_next = '0;
                end
            end
            S_LEN: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) begin
                    count_next    = n_full;
                    byte_idx_next = byte_idx_reg + BIW'(1);
                    if (byte_idx_reg == BIW'(3)) begin
                        byte_idx_next = '0;
                        if (n_full == 32'd0)
                            state_next = S_DONE;
                        else if ({1'b0, n_full} > CAP)
                            state_next = S_ERR;
                        else
                            state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) begin
                    if (byte_idx_reg == BIW'(BPW - 1)) begin
                        byte_idx_next = '0;
                        state_next    = S_WRITE;
                    end else begin
                        byte_idx_next = byte_idx_reg + BIW'(1);
                    end
                end
            end
            S_WRITE: begin
                bus.we        = 1'b1;
                busy          = 1'b1;
                word_idx_next = word_idx_reg + 32'd1;
                if (word_idx_reg + 32'd1 == count_reg)
                    state_next = S_DONE;
                else
                    state_next = S_DATA;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next    = S_LEN;
                    count_next    = '0;
                    word_idx_next = '0;
                    byte_idx_next = '0;
                end
            end
            S_ERR: begin
                err = 1'b1;
                if (start) begin
                    state_next    = S_LEN;
                    count_next    = '0;
                    word_idx_next = '0;
                    byte_idx_next = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Word address wraps within the memory; upper and lower bits stay zero.
    assign bus.waddr = AW'({word_idx_reg[DEPTH-3:0], 2'b00});

    // One byte lane per generate block; lane k holds byte k of the current word.
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
        logic [7:0] lane_reg;

        always_ff @(posedge wclk or negedge rst_n) begin
            if (!rst_n)
                lane_reg <= '0;
            else if (state_reg == S_DATA && bus.byte_valid && byte_idx_reg == BIW'(gi))
                lane_reg <= bus.byte_data;
        end

        assign bus.wdata[8*gi +: 8] = lane_reg;
    end
endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader with a 4-word memory (DEPTH=4), random
// payloads, random byte_valid gaps and a word-level reference model.
module tb_inst_loader;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int CAP   = 4;

    logic wclk  = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err;

    inst_loader_if #(.AW(AW), .IW(IW)) bus ();

    inst_loader #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
        .wclk  (wclk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          ready_viol = 0;
    logic [31:0] pay [8];

    // Records every write strobe; byte_ready must never accompany one.
    always @(negedge wclk) begin
        if (bus.we === 1'b1) begin
            obs_addr.push_back(bus.waddr);
            obs_data.push_back(bus.wdata);
            if (bus.byte_ready !== 1'b0) ready_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int waited;
        repeat (gap) begin
            @(negedge wclk);
            bus.byte_valid = 1'b0;
        end
        @(negedge wclk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        start          = with_start;
        waited = 0;
        while (bus.byte_ready !== 1'b1 && waited < 64) begin
            @(negedge wclk);
            waited++;
        end
        n_vec++;
        if (bus.byte_ready !== 1'b1) begin
            n_err++;
            $display("FAIL byte_accept: byte_ready=%b after %0d cycles, required 1", bus.byte_ready, waited);
        end
        @(posedge wclk);
        #1;
        bus.byte_valid = 1'b0;
        start          = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge wclk);
        start = 1'b1;
        @(negedge wclk);
        start = 1'b0;
        n_vec++;
        if (bus.byte_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL start_to_len: ready=%b busy=%b done=%b err=%b, required 1 1 0 0",
                     bus.byte_ready, busy, done, err);
        end
    endtask

    task automatic send_header(input logic [31:0] n, input int gap_max);
        for (int k = 0; k < 4; k++)
            send_byte(8'((n >> (8 * k)) & 32'hFF), $urandom_range(0, gap_max), 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input int gap_max, input bit start_mid);
        logic [31:0] exp_a;
        exp_a = 32'(idx) * 32'd4;
        for (int k = 0; k < 4; k++)
            send_byte(8'((w >> (8 * k)) & 32'hFF), $urandom_range(0, gap_max), start_mid && (k == 1));
        @(negedge wclk);
        n_vec++;
        if (bus.we !== 1'b1 || bus.waddr !== exp_a || bus.wdata !== w || bus.byte_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL write_cycle word %0d: we=%b waddr=%h wdata=%h ready=%b busy=%b, required we=1 waddr=%h wdata=%h ready=0 busy=1",
                     idx, bus.we, bus.waddr, bus.wdata, bus.byte_ready, busy, exp_a, w);
        end
    endtask

    // Runs a full load of n words from pay[] and checks every write against the model.
    task automatic run_load(input logic [31:0] n, input int gap_max, input bit start_mid, input string name);
        int  exp_writes;
        bit  exp_err;
        exp_err    = (n > 32'(CAP));
        exp_writes = (n == 0 || exp_err) ? 0 : int'(n);
        obs_addr.delete();
        obs_data.delete();
        ready_viol = 0;
        pulse_start();
        send_header(n, gap_max);
        for (int i = 0; i < exp_writes; i++)
            send_word(pay[i], i, gap_max, start_mid && i == 0);
        @(negedge wclk);
        n_vec++;
        if (done !== !exp_err || err !== exp_err || busy !== 1'b0 || bus.we !== 1'b0) begin
            n_err++;
            $display("FAIL %s end_status n=%0d: done=%b err=%b busy=%b we=%b, required done=%b err=%b busy=0 we=0",
                     name, n, done, err, busy, bus.we, !exp_err, exp_err);
        end
        repeat (3) @(negedge wclk);
        n_vec++;
        if (obs_addr.size() != exp_writes || ready_viol != 0 || done !== !exp_err || err !== exp_err) begin
            n_err++;
            $display("FAIL %s write_count n=%0d: writes=%0d ready_viol=%0d done=%b err=%b, required writes=%0d ready_viol=0 done=%b err=%b",
                     name, n, obs_addr.size(), ready_viol, done, err, exp_writes, !exp_err, exp_err);
        end
        for (int i = 0; i < exp_writes && i < obs_addr.size(); i++) begin
            n_vec++;
            if (obs_addr[i] !== 32'(i) * 32'd4 || obs_data[i] !== pay[i]) begin
                n_err++;
                $display("FAIL %s write_log %0d: addr=%h data=%h, required addr=%h data=%h",
                         name, i, obs_addr[i], obs_data[i], 32'(i) * 32'd4, pay[i]);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        n_vec++;
        if (bus.byte_ready !== 1'b0 || bus.we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || bus.waddr !== '0 || bus.wdata !== '0) begin
            n_err++;
            $display("FAIL %s: ready=%b we=%b busy=%b done=%b err=%b waddr=%h wdata=%h, required all 0",
                     name, bus.byte_ready, bus.we, busy, done, err, bus.waddr, bus.wdata);
        end
    endtask

    task automatic test_reset();
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (2) @(posedge wclk);
        #1;
        check_all_zero("reset_state");
        @(negedge wclk);
        rst_n = 1'b1;
        // Bytes offered while idle must not be taken.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        repeat (3) @(negedge wclk);
        check_all_zero("idle_no_consume");
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_basic();
        pay[0] = 32'h0000_0013;
        pay[1] = 32'h0010_0093;
        run_load(32'd2, 0, 1'b0, "basic_two_words");
    endtask

    task automatic test_zero_len();
        run_load(32'd0, 0, 1'b0, "zero_len");
    endtask

    task automatic test_err_recover();
        run_load(32'd5, 0, 1'b0, "over_cap");
        run_load(32'h8000_0001, 2, 1'b0, "huge_len");
        run_load(32'($urandom_range(CAP + 1, 100000)), 1, 1'b0, "random_over_cap");
        pay[0] = $urandom;
        run_load(32'd1, 0, 1'b0, "recover_one_word");
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 3; i++) pay[i] = $urandom;
        run_load(32'd3, 0, 1'b0, "three_no_gaps");
        run_load(32'd3, 4, 1'b0, "three_with_gaps");
    endtask

    task automatic test_reset_midload();
        obs_addr.delete();
        pulse_start();
        send_header(32'd3, 0);
        send_byte(8'hEE, 0, 1'b0);
        send_byte(8'hDD, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_midload");
        @(negedge wclk);
        rst_n = 1'b1;
        n_vec++;
        if (obs_addr.size() != 0) begin
            n_err++;
            $display("FAIL reset_midload_no_write: writes=%0d, required 0", obs_addr.size());
        end
        pay[0] = $urandom;
        pay[1] = $urandom;
        run_load(32'd2, 1, 1'b0, "after_reset");
    endtask

    task automatic test_start_mid_full();
        for (int i = 0; i < CAP; i++) pay[i] = $urandom;
        run_load(32'(CAP), 2, 1'b1, "full_cap_start_mid");
    endtask

    task automatic test_random_loads();
        for (int t = 0; t < 8; t++) begin
            logic [31:0] n;
            n = 32'($urandom_range(0, CAP + 2));
            for (int i = 0; i < CAP; i++) pay[i] = $urandom;
            run_load(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random_load");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_err_recover();
        test_gaps();
        test_reset_midload();
        test_start_mid_full();
        test_random_loads();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
